// File: rtl/test_div.sv
// Fully pipelined restoring divider: {quotient, fractional} = floor(dividend * 2^FRAC_W / divisor).
// One operand pair per enabled cycle; fixed latency of DIVIDEND_W + FRAC_W + 2 enabled cycles.
module test_div #(
  parameter int DIVIDEND_W = 25,
  parameter int DIVISOR_W  = 25,
  parameter int FRAC_W     = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  output logic                  rfd,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [FRAC_W-1:0]     fractional
);

  localparam int NS = DIVIDEND_W + FRAC_W;  // division steps, one quotient bit each

  // Stage 0 is the input register; stage s holds the state after s division steps.
  logic [DIVISOR_W-1:0]  rem_q [NS];
  logic [DIVISOR_W-1:0]  rem_d [NS];
  logic [DIVIDEND_W-1:0] num_q [NS];
  logic [DIVIDEND_W-1:0] num_d [NS];
  logic [DIVISOR_W-1:0]  den_q [NS];
  logic [DIVISOR_W-1:0]  den_d [NS];
  logic [NS-1:0]         quo_q [NS+1];
  logic [NS-1:0]         quo_d [NS+1];
  logic [NS-1:0]         out_q;
  logic                  rfd_q;

  logic [DIVISOR_W:0]    shifted;
  logic [DIVISOR_W:0]    diff;
  logic                  ge;

  // NOTE: every variable gets an assignment on every pass through this block, so no latches are inferred.
  always_comb begin
    rem_d[0] = '0;
    num_d[0] = dividend;
    den_d[0] = divisor;
    quo_d[0] = '0;
    shifted  = '0;
    diff     = '0;
    ge       = 1'b0;
    for (int s = 1; s <= NS; s++) begin
      // Dividend bits run out after DIVIDEND_W steps; the zeros shifted in feed the fraction steps.
      shifted  = {rem_q[s-1], num_q[s-1][DIVIDEND_W-1]};
      diff     = shifted - {1'b0, den_q[s-1]};
      ge       = (shifted >= {1'b0, den_q[s-1]});
      quo_d[s] = {quo_q[s-1][NS-2:0], ge};
      if (s < NS) begin
        rem_d[s] = ge ? diff[DIVISOR_W-1:0] : shifted[DIVISOR_W-1:0];
        num_d[s] = num_q[s-1] << 1;
        den_d[s] = den_q[s-1];
      end
    end
  end

  // NOTE: the whole stage array is cleared on reset so no X ever reaches the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NS; s++) begin
        rem_q[s] <= '0;
        num_q[s] <= '0;
        den_q[s] <= '0;
      end
      for (int s = 0; s <= NS; s++) quo_q[s] <= '0;
      out_q <= '0;
      rfd_q <= 1'b0;
    end else begin
      rfd_q <= 1'b1;
      // NOTE: non-blocking assignments let every stage sample its predecessor's old value on the same edge.
      if (ce) begin
        for (int s = 0; s < NS; s++) begin
          rem_q[s] <= rem_d[s];
          num_q[s] <= num_d[s];
          den_q[s] <= den_d[s];
        end
        for (int s = 0; s <= NS; s++) quo_q[s] <= quo_d[s];
        out_q <= quo_q[NS];
      end
    end
  end

  assign quotient   = out_q[NS-1:FRAC_W];
  assign fractional = out_q[FRAC_W-1:0];
  assign rfd        = rfd_q;

endmodule

// File: tb/tb_test_div.sv
// Directed and streaming checks for test_div; expected results come from hand-computed
// constants plus a floor(D*64/V) reference carried through a 33-deep delay line.
module tb_test_div;

  logic        clk;
  logic        rst;
  logic        ce;
  logic        rfd;
  logic [24:0] dividend;
  logic [24:0] divisor;
  logic [24:0] quotient;
  logic [5:0]  fractional;

  int errors = 0;
  int checks = 0;

  logic [30:0] exp_pipe [$];
  logic [30:0] exp_out;
  bit          exp_known;

  test_div dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .rfd        (rfd),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .fractional (fractional)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [30:0] ref_div(input logic [24:0] d, input logic [24:0] v);
    logic [30:0] n;
    n = {d, 6'b0};
    if (v == 25'd0) return '1;
    return n / {6'b0, v};
  endfunction

  // Drives one edge; on enabled edges the expected value of the captured pair enters the delay line.
  task automatic step(input logic en, input logic [24:0] d, input logic [24:0] v, input logic [30:0] e);
    rst      = 1'b0;
    ce       = en;
    dividend = d;
    divisor  = v;
    @(posedge clk);
    #1;
    if (en) begin
      exp_pipe.push_back(e);
      if (exp_pipe.size() > 32) begin
        exp_out   = exp_pipe.pop_front();
        exp_known = 1'b1;
      end
    end
  endtask

  task automatic do_reset(input int n, input logic en);
    rst = 1'b1;
    ce  = en;
    repeat (n) @(posedge clk);
    #1;
    exp_pipe.delete();
    exp_known = 1'b0;
  endtask

  task automatic test_reset;
    do_reset(2, 1'b1);
    checks += 3;
    if (quotient !== 25'd0) begin errors++; $display("FAIL reset_quotient: got %0d, expected 0", quotient); end
    if (fractional !== 6'd0) begin errors++; $display("FAIL reset_fractional: got %0d, expected 0", fractional); end
    if (rfd !== 1'b0) begin errors++; $display("FAIL reset_rfd: got %b, expected 0", rfd); end
  endtask

  task automatic test_basic;
    step(1'b1, 25'd100, 25'd7, {25'd14, 6'd18});
    checks++;
    if (rfd !== 1'b1) begin errors++; $display("FAIL basic_rfd: got %b, expected 1", rfd); end
    repeat (31) step(1'b1, 25'd0, 25'd0, '1);
    // One edge before the result is due, the zeroed pipeline (0/0) is still on the outputs.
    checks++;
    if ({quotient, fractional} !== '1) begin
      errors++; $display("FAIL basic_early: got q=%0d f=%0d, expected q=33554431 f=63", quotient, fractional);
    end
    step(1'b1, 25'd0, 25'd0, '1);
    checks += 2;
    if (quotient !== 25'd14) begin errors++; $display("FAIL basic_quotient: got %0d, expected 14", quotient); end
    if (fractional !== 6'd18) begin errors++; $display("FAIL basic_fractional: got %0d, expected 18", fractional); end
  endtask

  task automatic test_fraction;
    logic [24:0] vd [5];
    logic [24:0] vv [5];
    logic [30:0] ve [5];
    vd = '{25'd1, 25'd3, 25'd64, 25'd33554431, 25'd0};
    vv = '{25'd2, 25'd4, 25'd8,  25'd1,        25'd5};
    ve = '{{25'd0, 6'd32}, {25'd0, 6'd48}, {25'd8, 6'd0}, {25'd33554431, 6'd0}, {25'd0, 6'd0}};
    for (int i = 0; i < 5 + 32; i++) begin
      if (i < 5) step(1'b1, vd[i], vv[i], ve[i]);
      else       step(1'b1, 25'd9, 25'd2, {25'd4, 6'd32});
      if (exp_known) begin
        checks++;
        if ({quotient, fractional} !== exp_out) begin
          errors++;
          $display("FAIL fraction t=%0d: got q=%0d f=%0d, expected q=%0d f=%0d",
                   i, quotient, fractional, exp_out[30:6], exp_out[5:0]);
        end
      end
    end
  endtask

  task automatic test_streaming;
    logic [24:0] vd [10];
    logic [24:0] vv [10];
    logic [30:0] ve [10];
    logic [24:0] rd;
    logic [24:0] rv;
    vd = '{25'd1000, 25'd7, 25'd5,  25'd255, 25'd1,  25'd1,  25'd33554431, 25'd33554430, 25'd1000000, 25'd12345};
    vv = '{25'd3,    25'd7, 25'd10, 25'd16,  25'd64, 25'd65, 25'd33554431, 25'd33554431, 25'd999,     25'd100};
    ve = '{{25'd333, 6'd21}, {25'd1, 6'd0}, {25'd0, 6'd32}, {25'd15, 6'd60}, {25'd0, 6'd1},
           {25'd0, 6'd0}, {25'd1, 6'd0}, {25'd0, 6'd63}, {25'd1001, 6'd0}, {25'd123, 6'd28}};
    for (int i = 0; i < 10 + 1000 + 32; i++) begin
      if (i < 10) begin
        step(1'b1, vd[i], vv[i], ve[i]);
      end else if (i < 1010) begin
        rd = 25'($urandom_range(0, 33554431));
        rv = (i % 3 == 0) ? 25'($urandom_range(1, 255)) : 25'($urandom_range(1, 33554431));
        step(1'b1, rd, rv, ref_div(rd, rv));
      end else begin
        step(1'b1, 25'd9, 25'd2, {25'd4, 6'd32});
      end
      if (exp_known) begin
        checks++;
        if ({quotient, fractional} !== exp_out) begin
          errors++;
          $display("FAIL stream t=%0d: got q=%0d f=%0d, expected q=%0d f=%0d",
                   i, quotient, fractional, exp_out[30:6], exp_out[5:0]);
        end
      end
    end
  endtask

  task automatic test_stall;
    logic [24:0] vd [5];
    logic [24:0] vv [5];
    logic [30:0] ve [5];
    int          fed;
    bit          en;
    vd = '{25'd20, 25'd77, 25'd5,  25'd1023, 25'd40000};
    vv = '{25'd3,  25'd11, 25'd8,  25'd2,    25'd7};
    ve = '{{25'd6, 6'd42}, {25'd7, 6'd0}, {25'd0, 6'd40}, {25'd511, 6'd32}, {25'd5714, 6'd18}};
    fed = 0;
    // One stall while operands go in, a second while the first results are coming out.
    for (int t = 0; t < 60; t++) begin
      en = !((t >= 3 && t < 10) || (t >= 42 && t < 49));
      if (!en) begin
        step(1'b0, 25'd999, 25'd1, '0);
      end else if (fed < 5) begin
        step(1'b1, vd[fed], vv[fed], ve[fed]);
        fed++;
      end else begin
        step(1'b1, 25'd9, 25'd2, {25'd4, 6'd32});
      end
      if (exp_known) begin
        checks++;
        if ({quotient, fractional} !== exp_out) begin
          errors++;
          $display("FAIL stall t=%0d ce=%0b: got q=%0d f=%0d, expected q=%0d f=%0d",
                   t, en, quotient, fractional, exp_out[30:6], exp_out[5:0]);
        end
      end
    end
  endtask

  task automatic test_div_zero;
    step(1'b1, 25'd12345, 25'd0, {25'd33554431, 6'd63});
    step(1'b1, 25'd50, 25'd5, {25'd10, 6'd0});
    for (int i = 0; i < 33; i++) begin
      step(1'b1, 25'd9, 25'd2, {25'd4, 6'd32});
      if (exp_known) begin
        checks++;
        if ({quotient, fractional} !== exp_out) begin
          errors++;
          $display("FAIL div_zero t=%0d: got q=%0d f=%0d, expected q=%0d f=%0d",
                   i, quotient, fractional, exp_out[30:6], exp_out[5:0]);
        end
      end
    end
  endtask

  task automatic test_reset_midflight;
    step(1'b1, 25'd100, 25'd7, {25'd14, 6'd18});
    repeat (9) step(1'b1, 25'd0, 25'd1, '0);
    // Reset wins over a deasserted clock enable.
    do_reset(1, 1'b0);
    checks += 3;
    if (quotient !== 25'd0) begin errors++; $display("FAIL midreset_quotient: got %0d, expected 0", quotient); end
    if (fractional !== 6'd0) begin errors++; $display("FAIL midreset_fractional: got %0d, expected 0", fractional); end
    if (rfd !== 1'b0) begin errors++; $display("FAIL midreset_rfd: got %b, expected 0", rfd); end
    step(1'b1, 25'd0, 25'd1, '0);
    checks++;
    if (rfd !== 1'b1) begin errors++; $display("FAIL midreset_rfd_rise: got %b, expected 1", rfd); end
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 25'd0, 25'd1, '0);
      checks++;
      if (quotient === 25'd14 && fractional === 6'd18) begin
        errors++; $display("FAIL midreset_discard t=%0d: got q=%0d f=%0d, expected anything but 14/18", i, quotient, fractional);
      end
      if (exp_known) begin
        checks++;
        if ({quotient, fractional} !== exp_out) begin
          errors++;
          $display("FAIL midreset_flush t=%0d: got q=%0d f=%0d, expected q=%0d f=%0d",
                   i, quotient, fractional, exp_out[30:6], exp_out[5:0]);
        end
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    ce        = 1'b0;
    dividend  = '0;
    divisor   = '0;
    exp_out   = '0;
    exp_known = 1'b0;
    test_reset();
    test_basic();
    test_fraction();
    test_streaming();
    test_stall();
    test_div_zero();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/test_div.md
Name: test_div

Overview:
- Fully pipelined unsigned integer divider with a 6-bit binary fractional remainder output.
- Used by the Otsu threshold block to compute class weights: sum_n0/sum_n and sum_n1/sum_n. The fractional field gives each weight as a 6-bit fixed-point value.
- Accepts one new operand pair on every clock-enabled cycle. Results emerge after a fixed latency.

Parameters:
- DIVIDEND_W, 25, dividend and quotient width.
- DIVISOR_W, 25, divisor width.
- FRAC_W, 6, fractional output width (bits below the binary point).
- Latency is derived, not a parameter: LAT = DIVIDEND_W + FRAC_W + 2 = 33 enabled cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- ce  input  1  clock enable; the whole pipeline advances only when ce=1.
- rfd  output  1  ready-for-data; 1 whenever the core can accept operands.
- dividend  input  25  unsigned dividend.
- divisor  input  25  unsigned divisor.
- quotient  output  25  unsigned integer quotient, floor(dividend/divisor).
- fractional  output  6  floor(remainder*64/divisor), i.e. 6 fractional quotient bits.

Behaviour:
- Math: quotient = floor(D/V); R = D - quotient*V; fractional = floor(R*2^FRAC_W / V). Equivalently, {quotient,fractional} = floor(D*64/V). All arithmetic is unsigned.
- Structure: 33 enabled stages in total.
  - 1 input register stage.
  - 25 restoring-division stages for integer bits, MSB first.
  - 6 restoring stages for fractional bits, each shifting the partial remainder left with a zero appended.
  - 1 output register stage.
- Partial remainders are carried at DIVISOR_W+1 bits so the trial subtraction never overflows.
- Latency: operands present at enabled edge k appear on quotient/fractional immediately after enabled edge k+32 (33 enabled edges including the capture edge). This is constant and independent of operand values.
- Throughput: one result per enabled cycle; consecutive operand pairs produce consecutive results in order.
- ce=0: every pipeline register, including the output register, holds its value. Outputs stay stable and no operands are sampled. Stalled cycles do not count toward latency.
- rfd: registered. It goes to 0 during reset and to 1 on the first clock edge after rst deasserts, then stays 1. It is independent of ce; this is a pipelined core with no busy state.
- Reset:
  - rst=1 at a clock edge clears all pipeline stages; quotient=0, fractional=0, rfd=0.
  - rst has priority over ce.
  - Reset mid-operation discards all in-flight results.
  - Until 33 enabled cycles after reset, outputs show results of the zeroed pipeline. The 0/0 case is defined by the divide-by-zero rule below, so these outputs are all ones, not undefined.
- Divide by zero (divisor=0): quotient = all ones (33554431), fractional = all ones (63). This falls out naturally from restoring division because every trial subtraction succeeds; no separate flag is provided.
- Dividend < divisor: quotient=0, and fractional carries the full result (e.g. 1/2 -> fractional 32).
- Boundary widths: max dividend 2^25-1 with divisor 1 gives quotient 2^25-1 and fractional 0. No overflow is possible for divisor >= 1.
- No X propagation: all internal registers are reset.

Test Plan:
- Basic division: rst 2 cycles, ce=1, dividend=100, divisor=7 -> after 33 cycles quotient=14, fractional=18 (remainder 2, 128/7=18); rfd=1 from the first post-reset cycle.
- Fraction only / exact: 1/2 -> q=0, f=32; 3/4 -> q=0, f=48; 64/8 -> q=8, f=0; 33554431/1 -> q=33554431, f=0.
- Streaming: apply 10 distinct operand pairs on 10 consecutive cycles -> 10 results on consecutive cycles starting at cycle 33, in order and bit-exact versus a floor(D*64/V) model. Add 1000 random pairs with divisor != 0.
- ce stall: feed 5 pairs, drop ce for 7 cycles mid-stream -> outputs frozen during the stall; the results sequence resumes unchanged; each result appears after 33 enabled cycles plus the 7 stalled cycles.
- Divide by zero: 12345/0 -> quotient=33554431, fractional=63; the following valid pair 50/5 -> q=10, f=0 on the next cycle.
- Reset mid-flight: start 100/7, assert rst at cycle 10 for 1 cycle -> quotient=0, fractional=0, rfd=0 after that edge; the 100/7 result never appears; rfd=1 one cycle after rst falls.
